// File: rtl/fft_delay_buf_01_if.sv
// Purpose: bundles the stage-01 delay buffer's block input, delayed block output and status.
// Latency: none (wiring only).
// Backpressure: none; din_valid is an accept strobe, the buffer never stalls its producer.
// Ports: din_valid/din_R_01/din_Q_01 (16-lane block in), dout_valid/dout_R_dly/dout_Q_dly
//        (delayed block out), mux_sel (add/sub select back to stage 00), full (buffer primed).
interface fft_delay_buf_01_if #(
  parameter int DATA_WIDTH = 10
);
  logic                         din_valid;
  logic signed [DATA_WIDTH-1:0] din_R_01   [0:15];
  logic signed [DATA_WIDTH-1:0] din_Q_01   [0:15];
  logic                         mux_sel;
  logic                         dout_valid;
  logic signed [DATA_WIDTH-1:0] dout_R_dly [0:15];
  logic signed [DATA_WIDTH-1:0] dout_Q_dly [0:15];
  logic                         full;

  // Producer / consumer side (stage-00 select mux and downstream butterfly).
  modport master (
    output din_valid, din_R_01, din_Q_01,
    input  mux_sel, dout_valid, dout_R_dly, dout_Q_dly, full
  );

  // Delay buffer side.
  modport slave (
    input  din_valid, din_R_01, din_Q_01,
    output mux_sel, dout_valid, dout_R_dly, dout_Q_dly, full
  );
endinterface

// File: rtl/fft_delay_buf_01.sv
// Purpose: DEPTH-block shift-register delay line for 16-lane complex FFT blocks, plus add/sub select.
// Latency: a block leaves 1 clk after the accept that evicts it, i.e. DEPTH accepts after entry.
// Backpressure: none; every din_valid cycle is accepted unless rst or clear is high.
// Ports: clk, rst (sync, active-high), clear (sync flush of counters/valid, below rst),
//        bus (slave modport of fft_delay_buf_01_if).
module fft_delay_buf_01 #(
  parameter int DATA_WIDTH = 10,
  parameter int DEPTH      = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  fft_delay_buf_01_if.slave  bus
);
  localparam int LANES = 16;
  localparam int FW    = $clog2(DEPTH + 1);
  localparam int BW    = $clog2(2 * DEPTH);
  localparam logic [FW-1:0] FILL_MAX = FW'(DEPTH);
  localparam logic [BW-1:0] BLK_HALF = BW'(DEPTH);
  localparam logic [BW-1:0] BLK_LAST = BW'(2 * DEPTH - 1);

  typedef logic signed [DATA_WIDTH-1:0] lane_t;
  typedef enum logic {FILL, RUN} state_t;

  state_t        state_q, state_d;
  logic [FW-1:0] fill_cnt_q, fill_cnt_d;
  logic [BW-1:0] blk_cnt_q, blk_cnt_d;
  logic          mux_sel_q, mux_sel_d;
  logic          dout_valid_q, dout_valid_d;
  lane_t         mem_r_q [DEPTH][LANES];
  lane_t         mem_r_d [DEPTH][LANES];
  lane_t         mem_q_q [DEPTH][LANES];
  lane_t         mem_q_d [DEPTH][LANES];
  lane_t         dout_r_q [LANES];
  lane_t         dout_r_d [LANES];
  lane_t         dout_q_q [LANES];
  lane_t         dout_q_d [LANES];

  always_comb begin
    state_d      = state_q;
    fill_cnt_d   = fill_cnt_q;
    blk_cnt_d    = blk_cnt_q;
    mux_sel_d    = mux_sel_q;
    dout_valid_d = 1'b0;
    mem_r_d      = mem_r_q;
    mem_q_d      = mem_q_q;
    dout_r_d     = dout_r_q;
    dout_q_d     = dout_q_q;

    if (clear) begin
      // Flush bookkeeping only; the data arrays keep their contents and the
      // same-cycle input block is dropped.
      state_d    = FILL;
      fill_cnt_d = '0;
      blk_cnt_d  = '0;
      mux_sel_d  = 1'b0;
    end else if (bus.din_valid) begin
      mem_r_d[0] = bus.din_R_01;
      mem_q_d[0] = bus.din_Q_01;
      for (int k = 1; k < DEPTH; k++) begin
        mem_r_d[k] = mem_r_q[k-1];
        mem_q_d[k] = mem_q_q[k-1];
      end

      // Output data only moves when it is flagged valid, so the bus stays
      // frozen while the line is still filling.
      if (state_q == RUN) begin
        dout_r_d     = mem_r_q[DEPTH-1];
        dout_q_d     = mem_q_q[DEPTH-1];
        dout_valid_d = 1'b1;
      end

      if (fill_cnt_q != FILL_MAX) begin
        fill_cnt_d = fill_cnt_q + FW'(1);
      end
      state_d = (fill_cnt_d == FILL_MAX) ? RUN : FILL;

      blk_cnt_d = (blk_cnt_q == BLK_LAST) ? '0 : blk_cnt_q + BW'(1);
      mux_sel_d = (blk_cnt_d >= BLK_HALF);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FILL;
      fill_cnt_q   <= '0;
      blk_cnt_q    <= '0;
      mux_sel_q    <= 1'b0;
      dout_valid_q <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        dout_r_q[i] <= '0;
        dout_q_q[i] <= '0;
        for (int k = 0; k < DEPTH; k++) begin
          mem_r_q[k][i] <= '0;
          mem_q_q[k][i] <= '0;
        end
      end
    end else begin
      state_q      <= state_d;
      fill_cnt_q   <= fill_cnt_d;
      blk_cnt_q    <= blk_cnt_d;
      mux_sel_q    <= mux_sel_d;
      dout_valid_q <= dout_valid_d;
      mem_r_q      <= mem_r_d;
      mem_q_q      <= mem_q_d;
      dout_r_q     <= dout_r_d;
      dout_q_q     <= dout_q_d;
    end
  end

  assign bus.full       = (state_q == RUN);
  assign bus.mux_sel    = mux_sel_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.dout_R_dly = dout_r_q;
  assign bus.dout_Q_dly = dout_q_q;
endmodule

// File: tb/tb_fft_delay_buf_01.sv
// Purpose: directed self-checking bench for fft_delay_buf_01 (DATA_WIDTH=10, DEPTH=4).
// Latency: inputs change after a falling edge, outputs are sampled at the next falling edge.
// Backpressure: not applicable; the bench drives din_valid directly.
module tb_fft_delay_buf_01;
  localparam int DW = 10;
  localparam int DP = 4;

  logic clk;
  logic rst;
  logic clear;
  int   nvec;
  int   nerr;

  fft_delay_buf_01_if #(.DATA_WIDTH(DW)) bif ();

  fft_delay_buf_01 #(.DATA_WIDTH(DW), .DEPTH(DP)) dut (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Block k, lane i: R = k*16+i, Q = -(k*16+i).
  function automatic logic signed [DW-1:0] lane_r(input int k, input int i);
    return DW'(k * 16 + i);
  endfunction

  function automatic logic signed [DW-1:0] lane_q(input int k, input int i);
    return DW'(-(k * 16 + i));
  endfunction

  task automatic set_blk(input int k);
    for (int i = 0; i < 16; i++) begin
      bif.din_R_01[i] = lane_r(k, i);
      bif.din_Q_01[i] = lane_q(k, i);
    end
  endtask

  task automatic set_const(input logic signed [DW-1:0] r, input logic signed [DW-1:0] q);
    for (int i = 0; i < 16; i++) begin
      bif.din_R_01[i] = r;
      bif.din_Q_01[i] = q;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bif.din_valid = 1'b0;
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    int bad;
    // din_valid held high during reset must be ignored.
    rst = 1'b1;
    clear = 1'b0;
    bif.din_valid = 1'b1;
    set_blk(7);
    cyc();
    cyc();
    nvec++;
    if (bif.dout_valid !== 1'b0) begin
      nerr++; $display("FAIL reset dout_valid: got %b need 0", bif.dout_valid);
    end
    nvec++;
    if (bif.mux_sel !== 1'b0) begin
      nerr++; $display("FAIL reset mux_sel: got %b need 0", bif.mux_sel);
    end
    nvec++;
    if (bif.full !== 1'b0) begin
      nerr++; $display("FAIL reset full: got %b need 0", bif.full);
    end
    bad = 0;
    for (int i = 0; i < 16; i++)
      if (bif.dout_R_dly[i] !== '0 || bif.dout_Q_dly[i] !== '0) bad++;
    nvec++;
    if (bad != 0) begin
      nerr++; $display("FAIL reset dout data: %0d nonzero lanes, R[0]=%0d need 0", bad, bif.dout_R_dly[0]);
    end
    rst = 1'b0;
    bif.din_valid = 1'b0;
    cyc();
  endtask

  // Blocks 0..9 back to back: full, dout_valid, mux_sel and delayed data per accept.
  task automatic test_back_to_back();
    int bad;
    for (int k = 0; k < 10; k++) begin
      set_blk(k);
      bif.din_valid = 1'b1;
      cyc();
      nvec++;
      if (bif.full !== (k >= 3)) begin
        nerr++; $display("FAIL b2b full after blk %0d: got %b need %b", k, bif.full, (k >= 3));
      end
      nvec++;
      if (bif.dout_valid !== (k >= 4)) begin
        nerr++; $display("FAIL b2b dout_valid after blk %0d: got %b need %b", k, bif.dout_valid, (k >= 4));
      end
      nvec++;
      if (bif.mux_sel !== (((k + 1) % 8) >= 4)) begin
        nerr++; $display("FAIL b2b mux_sel after accept %0d: got %b need %b", k + 1, bif.mux_sel, (((k + 1) % 8) >= 4));
      end
      if (k >= 4) begin
        bad = 0;
        for (int i = 0; i < 16; i++)
          if (bif.dout_R_dly[i] !== lane_r(k - 4, i) || bif.dout_Q_dly[i] !== lane_q(k - 4, i)) bad++;
        nvec++;
        if (bad != 0) begin
          nerr++;
          $display("FAIL b2b data after blk %0d: R[5]=%0d Q[5]=%0d need R[5]=%0d Q[5]=%0d",
                   k, bif.dout_R_dly[5], bif.dout_Q_dly[5], lane_r(k - 4, 5), lane_q(k - 4, 5));
        end
      end
    end
  endtask

  // In RUN after 10 accepts: accept, idle, accept, idle.
  task automatic test_idle_toggle();
    int bad;
    int exp_blk;
    logic exp_vld;
    logic exp_mux;
    for (int step = 0; step < 4; step++) begin
      exp_vld = (step % 2 == 0);
      if (exp_vld) set_blk(10 + step / 2);
      bif.din_valid = exp_vld;
      cyc();
      exp_blk = 6 + step / 2;            // idle cycles must not shift the line
      exp_mux = (step >= 2);             // 12th accept moves blk_cnt to 4
      nvec++;
      if (bif.dout_valid !== exp_vld) begin
        nerr++; $display("FAIL idle dout_valid step %0d: got %b need %b", step, bif.dout_valid, exp_vld);
      end
      nvec++;
      if (bif.mux_sel !== exp_mux) begin
        nerr++; $display("FAIL idle mux_sel step %0d: got %b need %b", step, bif.mux_sel, exp_mux);
      end
      bad = 0;
      for (int i = 0; i < 16; i++)
        if (bif.dout_R_dly[i] !== lane_r(exp_blk, i) || bif.dout_Q_dly[i] !== lane_q(exp_blk, i)) bad++;
      nvec++;
      if (bad != 0) begin
        nerr++;
        $display("FAIL idle data step %0d: R[0]=%0d need %0d", step, bif.dout_R_dly[0], lane_r(exp_blk, 0));
      end
    end
  endtask

  // Reset after 6 accepts; then blocks 20..24 must be the first to emerge.
  task automatic test_reset_mid();
    int bad;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      set_blk(k);
      bif.din_valid = 1'b1;
      cyc();
    end
    rst = 1'b1;
    set_blk(30);
    cyc();
    rst = 1'b0;
    nvec++;
    if (bif.full !== 1'b0 || bif.dout_valid !== 1'b0) begin
      nerr++; $display("FAIL rstmid flags: full=%b dout_valid=%b need 0 0", bif.full, bif.dout_valid);
    end
    for (int k = 20; k < 25; k++) begin
      set_blk(k);
      bif.din_valid = 1'b1;
      cyc();
      nvec++;
      if (bif.dout_valid !== (k == 24)) begin
        nerr++; $display("FAIL rstmid dout_valid after blk %0d: got %b need %b", k, bif.dout_valid, (k == 24));
      end
    end
    bad = 0;
    for (int i = 0; i < 16; i++)
      if (bif.dout_R_dly[i] !== lane_r(20, i) || bif.dout_Q_dly[i] !== lane_q(20, i)) bad++;
    nvec++;
    if (bad != 0) begin
      nerr++; $display("FAIL rstmid data: R[0]=%0d need 320", bif.dout_R_dly[0]);
    end
    bif.din_valid = 1'b0;
  endtask

  // Clear with din_valid after 3 accepts; the dropped block must never appear.
  task automatic test_clear();
    int bad;
    do_reset();
    for (int k = 10; k < 13; k++) begin
      set_blk(k);
      bif.din_valid = 1'b1;
      cyc();
    end
    clear = 1'b1;
    set_blk(30);
    cyc();
    clear = 1'b0;
    nvec++;
    if (bif.full !== 1'b0 || bif.mux_sel !== 1'b0 || bif.dout_valid !== 1'b0) begin
      nerr++;
      $display("FAIL clear flags: full=%b mux_sel=%b dout_valid=%b need 0 0 0", bif.full, bif.mux_sel, bif.dout_valid);
    end
    for (int k = 13; k < 18; k++) begin
      set_blk(k);
      bif.din_valid = 1'b1;
      cyc();
      nvec++;
      if (bif.full !== (k >= 16)) begin
        nerr++; $display("FAIL clear full after blk %0d: got %b need %b", k, bif.full, (k >= 16));
      end
      nvec++;
      if (bif.mux_sel !== (k >= 16)) begin
        nerr++; $display("FAIL clear mux_sel after blk %0d: got %b need %b", k, bif.mux_sel, (k >= 16));
      end
      nvec++;
      if (bif.dout_valid !== (k == 17)) begin
        nerr++; $display("FAIL clear dout_valid after blk %0d: got %b need %b", k, bif.dout_valid, (k == 17));
      end
    end
    bad = 0;
    for (int i = 0; i < 16; i++)
      if (bif.dout_R_dly[i] !== lane_r(13, i) || bif.dout_Q_dly[i] !== lane_q(13, i)) bad++;
    nvec++;
    if (bad != 0) begin
      nerr++; $display("FAIL clear data: R[0]=%0d need %0d", bif.dout_R_dly[0], lane_r(13, 0));
    end
    bif.din_valid = 1'b0;
  endtask

  // Full-scale values pass bit-exact.
  task automatic test_extremes();
    int bad;
    logic signed [DW-1:0] mn;
    logic signed [DW-1:0] mx;
    mn = DW'(-512);
    mx = DW'(511);
    do_reset();
    bif.din_valid = 1'b1;
    set_const(mn, mx);
    cyc();
    set_const(mx, mn);
    cyc();
    for (int k = 1; k < 5; k++) begin
      set_blk(k);
      cyc();
      if (k >= 3) begin
        bad = 0;
        for (int i = 0; i < 16; i++)
          if (bif.dout_R_dly[i] !== ((k == 3) ? mn : mx) || bif.dout_Q_dly[i] !== ((k == 3) ? mx : mn)) bad++;
        nvec++;
        if (bad != 0 || bif.dout_valid !== 1'b1) begin
          nerr++;
          $display("FAIL extremes after blk %0d: vld=%b R[0]=%0d Q[0]=%0d need vld=1 R[0]=%0d Q[0]=%0d",
                   k, bif.dout_valid, bif.dout_R_dly[0], bif.dout_Q_dly[0],
                   (k == 3) ? mn : mx, (k == 3) ? mx : mn);
        end
      end
    end
    bif.din_valid = 1'b0;
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    rst = 1'b1;
    clear = 1'b0;
    bif.din_valid = 1'b0;
    set_blk(0);
    test_reset();
    test_back_to_back();
    test_idle_toggle();
    test_reset_mid();
    test_clear();
    test_extremes();
    cyc();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/fft_delay_buf_01.md
FFT_DELAY_BUF_01 -- requirements
Module: fft_delay_buf_01

Interface
REQ-001 Parameter DATA_WIDTH, default 10, signed sample width per lane (R and Q).
REQ-002 Parameter DEPTH, default 4, delay in accepted 16-lane blocks; legal range 1..64.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 clear  input  1  synchronous flush of counters/valid; lower priority than rst.
REQ-006 din_valid  input  1  block on din_R_01/din_Q_01 accepted this cycle.
REQ-007 din_R_01  input  signed DATA_WIDTH x [0:15]  in-phase lanes from stage-00 add/sub select.
REQ-008 din_Q_01  input  signed DATA_WIDTH x [0:15]  quadrature lanes from stage-00 add/sub select.
REQ-009 mux_sel  output  1  add/sub select driven back to the stage-00 select mux.
REQ-010 dout_valid  output  1  dout_R_dly/dout_Q_dly hold a valid delayed block.
REQ-011 dout_R_dly  output  signed DATA_WIDTH x [0:15]  in-phase block delayed by DEPTH accepts.
REQ-012 dout_Q_dly  output  signed DATA_WIDTH x [0:15]  quadrature block delayed by DEPTH accepts.
REQ-013 full  output  1  high when DEPTH blocks are stored (state RUN).

Function
REQ-014 Storage: DEPTH entries mem[0..DEPTH-1], each 16 R + 16 Q lanes, shift-register organised.
REQ-015 On accept (din_valid=1): mem[0] <= din, mem[k] <= mem[k-1]; no movement when din_valid=0.
REQ-016 On accept: dout_R_dly/dout_Q_dly <= pre-shift mem[DEPTH-1]; latency exactly 1 clk after the accept that evicts it.
REQ-017 fill_cnt counts accepts, saturating at DEPTH; full = (fill_cnt == DEPTH).
REQ-018 States: FILL (fill_cnt<DEPTH), RUN (fill_cnt==DEPTH); FILL->RUN on the DEPTH-th accept; RUN->FILL only on rst or clear.
REQ-019 dout_valid <= din_valid AND full (evaluated pre-update); dout_valid is a one-cycle pulse per accept in RUN.
REQ-020 When dout_valid=0, dout_R_dly/dout_Q_dly hold their last value.
REQ-021 blk_cnt counts accepts modulo 2*DEPTH, width clog2(2*DEPTH), wraps 2*DEPTH-1 -> 0.
REQ-022 mux_sel = 1 when blk_cnt >= DEPTH, else 0; registered, reflects blk_cnt after the latest accept.
REQ-023 clear=1: fill_cnt, blk_cnt, mux_sel, dout_valid <= 0; state -> FILL; mem and dout data unchanged; din_valid in same cycle ignored.
REQ-024 rst and clear both high: rst behaviour applies.
REQ-025 No arithmetic on sample data; values pass bit-exact, no saturation or rounding.

Reset
REQ-026 rst=1 at a rising edge: all mem entries, dout_R_dly, dout_Q_dly = 0; dout_valid, mux_sel, full = 0; fill_cnt, blk_cnt = 0; state FILL.
REQ-027 Reset mid-operation discards all stored blocks; first dout_valid after reset follows DEPTH+1 new accepts.
REQ-028 din_valid ignored in any cycle with rst=1.

Verification (DEPTH=4, block k lane i: R = k*16+i, Q = -(k*16+i))
REQ-029 Continuous din_valid for blocks 0..9 -> full rises after block 3 accepted; dout_valid first high 1 clk after block 4 accepted with dout_R_dly[5]=5, dout_Q_dly[5]=-5; block 5 evicts block 1.
REQ-030 mux_sel over continuous accepts -> 0 after accepts 0..3 counted as blocks 1..3, 1 after 4th..7th accept, 0 again after 8th (wrap at 2*DEPTH=8).
REQ-031 din_valid toggled 1,0,1,0 in RUN -> dout_valid pulses only on cycles after accepts; data unchanged across idle cycles; no shift on idle.
REQ-032 rst asserted after 6 accepts, then 5 accepts of blocks 20..24 -> dout_valid first after block 24 with dout_R_dly[0]=320; no pre-reset data emerges.
REQ-033 clear and din_valid high together after 3 accepts -> input block dropped, full=0, mux_sel=0; then 5 accepts -> first dout_valid carries the first post-clear block.
REQ-034 Extreme values -512 and +511 on all lanes (DATA_WIDTH=10) -> emerge bit-exact after 4 further accepts.
